// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory/IO address control unit.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;

endpackage

// File: rtl/io_regs.sv
// Memory-mapped keyboard/display registers with their device handshakes.
module io_regs
  import lc3_pkg::*;
#(
  parameter logic [15:0] KBSR_ADDR = lc3_pkg::KBSR_ADDR,
  parameter logic [15:0] KBDR_ADDR = lc3_pkg::KBDR_ADDR,
  parameter logic [15:0] DSR_ADDR  = lc3_pkg::DSR_ADDR,
  parameter logic [15:0] DDR_ADDR  = lc3_pkg::DDR_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic        wr_ie,
  input  logic [7:0]  wr_char,
  output logic [15:0] rdata,
  input  logic        kb_strobe,
  input  logic [7:0]  kb_data,
  input  logic        disp_ack,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  output logic [15:0] kbsr,
  output logic [15:0] dsr
);

  logic        kb_ready;
  logic        kb_ie;
  logic        disp_ie;
  logic [15:0] kbdr;
  logic [15:0] ddr;
  logic        kbdr_rd;
  logic        kbsr_wr;
  logic        dsr_wr;
  logic        ddr_wr;

  assign kbdr_rd = rd_en && (addr == KBDR_ADDR);
  assign kbsr_wr = wr_en && (addr == KBSR_ADDR);
  assign dsr_wr  = wr_en && (addr == DSR_ADDR);
  assign ddr_wr  = wr_en && (addr == DDR_ADDR);

  // Display ready is exactly the absence of a pending character.
  always_comb begin
    kbsr            = 16'h0000;
    kbsr[READY_BIT] = kb_ready;
    kbsr[IE_BIT]    = kb_ie;
    dsr             = 16'h0000;
    dsr[READY_BIT]  = ~disp_valid;
    dsr[IE_BIT]     = disp_ie;
  end

  always_comb begin
    rdata = 16'h0000;
    if (addr == KBSR_ADDR)      rdata = kbsr;
    else if (addr == KBDR_ADDR) rdata = kbdr;
    else if (addr == DSR_ADDR)  rdata = dsr;
    else if (addr == DDR_ADDR)  rdata = ddr;
    else                        rdata = 16'h0000;
  end

  // A strobe landing on the same edge as a KBDR read still captures its character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_ready <= 1'b0;
      kb_ie    <= 1'b0;
      kbdr     <= 16'h0000;
    end else begin
      if (kb_strobe && (!kb_ready || kbdr_rd)) begin
        kbdr     <= {8'h00, kb_data};
        kb_ready <= 1'b1;
      end else if (kbdr_rd) begin
        kb_ready <= 1'b0;
      end
      if (kbsr_wr) kb_ie <= wr_ie;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
      disp_ie    <= 1'b0;
      ddr        <= 16'h0000;
    end else begin
      if (ddr_wr && !disp_valid) begin
        ddr        <= {8'h00, wr_char};
        disp_data  <= wr_char;
        disp_valid <= 1'b1;
      end else if (disp_ack && disp_valid) begin
        disp_valid <= 1'b0;
      end
      if (dsr_wr) disp_ie <= wr_ie;
    end
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// LC-3 MAR/MDR address control: steers accesses to fixed-latency RAM or the
// keyboard/display registers and pulses R when the access completes.
module mem_io_ctrl
  import lc3_pkg::*;
#(
  parameter int          MEM_LATENCY = 2,
  parameter logic [15:0] KBSR_ADDR   = lc3_pkg::KBSR_ADDR,
  parameter logic [15:0] KBDR_ADDR   = lc3_pkg::KBDR_ADDR,
  parameter logic [15:0] DSR_ADDR    = lc3_pkg::DSR_ADDR,
  parameter logic [15:0] DDR_ADDR    = lc3_pkg::DDR_ADDR
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR_OUT,
  input  logic [15:0] MDR_OUT,
  output logic [15:0] MIOMUX_OUT,
  output logic        R,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        KB_STROBE,
  input  logic [7:0]  KB_DATA,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_DATA,
  input  logic        DISP_ACK,
  output logic [15:0] KBSR_OUT,
  output logic [15:0] DSR_OUT
);

  localparam int CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_access;
  logic          io_hit;
  logic          io_req;
  logic [15:0]   io_rdata;

  assign io_hit = (MAR_OUT == KBSR_ADDR) || (MAR_OUT == KBDR_ADDR) ||
                  (MAR_OUT == DSR_ADDR)  || (MAR_OUT == DDR_ADDR);
  assign io_req = (state == IDLE) && MIO_EN && io_hit;

  io_regs #(
    .KBSR_ADDR (KBSR_ADDR),
    .KBDR_ADDR (KBDR_ADDR),
    .DSR_ADDR  (DSR_ADDR),
    .DDR_ADDR  (DDR_ADDR)
  ) u_io_regs (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .rd_en      (io_req && !R_W),
    .wr_en      (io_req && R_W),
    .addr       (MAR_OUT),
    .wr_ie      (MDR_OUT[IE_BIT]),
    .wr_char    (MDR_OUT[7:0]),
    .rdata      (io_rdata),
    .kb_strobe  (KB_STROBE),
    .kb_data    (KB_DATA),
    .disp_ack   (DISP_ACK),
    .disp_valid (DISP_VALID),
    .disp_data  (DISP_DATA),
    .kbsr       (KBSR_OUT),
    .dsr        (DSR_OUT)
  );

  // The strobe cycle is not counted, so the counter reads 1 exactly when RAM data is valid.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_access  <= 1'b0;
      MIOMUX_OUT <= 16'h0000;
      R          <= 1'b0;
      MEM_EN     <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= 16'h0000;
      MEM_WDATA  <= 16'h0000;
    end else begin
      R      <= 1'b0;
      MEM_EN <= 1'b0;
      MEM_WE <= 1'b0;
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            if (io_hit) begin
              if (!R_W) MIOMUX_OUT <= io_rdata;
              R     <= 1'b1;
              state <= DONE;
            end else begin
              MEM_EN    <= 1'b1;
              MEM_WE    <= R_W;
              MEM_ADDR  <= MAR_OUT;
              MEM_WDATA <= MDR_OUT;
              wr_access <= R_W;
              cnt       <= CW'(MEM_LATENCY);
              state     <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (!MEM_EN) begin
            if (cnt == CW'(1)) begin
              if (!wr_access) MIOMUX_OUT <= MEM_RDATA;
              R     <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
